// File: rtl/data_bus_responder.sv
// Data-memory slave for the core's load/store bus: byte/half/word RMW stores and extended loads after wait states.
// Define MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of aligning them down.
module data_bus_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_W      = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [2:0]        funct3,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int unsigned IDX_W     = ADDR_W - 2;
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

   state_t            state, next_state;
   logic [3:0]        cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        f3_q;
   logic [31:0]       mem [DEPTH];

   logic [IDX_W-1:0]  idx_c;
   logic              unsup_c, misalign_c, bad_c;
   logic [3:0]        be_c;
   logic [31:0]       wword_c, rword_c, ld_c;
   logic [7:0]        byte_c;
   logic [15:0]       half_c;
   logic              ready_d, busy_d, err_d, wr_en_c, ld_en_c;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? XFER : WAIT;
         WAIT: if (cnt == 4'd0) next_state = XFER;
         XFER: next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode, registered below so ready/busy/err line up with the state they describe
   always_comb begin
      ready_d = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
      wr_en_c = 1'b0;
      ld_en_c = 1'b0;
      busy_d  = (next_state != IDLE);
      ready_d = (next_state == DONE);
      err_d   = (next_state == DONE) && bad_c;
      wr_en_c = (state == XFER) && we_q;
      ld_en_c = (state == XFER) && !we_q;
   end

   // Request latch and wait-state counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
      end else if (state == IDLE && req) begin
         cnt     <= WAIT_INIT;
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
         f3_q    <= funct3;
      end else if (state == WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Access decode: error classification, store lanes and load extraction
   always_comb begin
      idx_c   = addr_q[ADDR_W-1:2];
      unsup_c = !(f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef MISALIGN_TRAP_EN
      misalign_c = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                   (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
      misalign_c = 1'b0;
`endif
      bad_c   = unsup_c || misalign_c;
      rword_c = mem[idx_c];

      be_c    = 4'b0000;
      wword_c = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr_q[1:0];
            wword_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
            wword_c = {2{wdata_q[15:0]}};
         end
         2'b10:   be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
      if (bad_c) be_c = 4'b0000;

      case (addr_q[1:0])
         2'd0:    byte_c = rword_c[7:0];
         2'd1:    byte_c = rword_c[15:8];
         2'd2:    byte_c = rword_c[23:16];
         default: byte_c = rword_c[31:24];
      endcase
      half_c = addr_q[1] ? rword_c[31:16] : rword_c[15:0];

      case (f3_q)
         3'b000:  ld_c = {{24{byte_c[7]}}, byte_c};
         3'b100:  ld_c = {24'd0, byte_c};
         3'b001:  ld_c = {{16{half_c[15]}}, half_c};
         3'b101:  ld_c = {16'd0, half_c};
         3'b010:  ld_c = rword_c;
         default: ld_c = 32'd0;
      endcase
      if (bad_c) ld_c = 32'd0;
   end

   // Registered bus outputs; rdata only moves on a completed load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= 32'd0;
         ready <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         ready <= ready_d;
         busy  <= busy_d;
         err   <= err_d;
         if (ld_en_c) rdata <= ld_c;
      end
   end

   // Word RAM with per-byte write enables; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx_c][8*i +: 8] <= wword_c[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: directed loads/stores, ignored requests, error cases and mid-transaction reset.
module tb_data_bus_responder;
   localparam int unsigned W      = 2;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req = 1'b0;
   logic              we = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       wdata = 32'd0;
   logic [2:0]        funct3 = 3'd0;
   logic [31:0]       rdata;
   logic              ready, busy, err;

   data_bus_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .funct3(funct3), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_rd = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && ready === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: got ready=1 expected no pending transaction (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rdata", rdata, e.rd);
            check("err", 32'(err), 32'(e.er));
            check("latency", 32'(cyc - e.cyc), 32'(W + 2));
         end
      end
   end

   task automatic xact(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_err,
                       input bit toggle);
      exp_t e;
      int   nb;
      bit   got;
      @(negedge clk);
      if (!w) last_rd = exp_rd;
      e.rd  = last_rd;
      e.er  = exp_err;
      e.cyc = cyc;
      sb.push_back(e);
      req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
      @(negedge clk);
      req = 1'b0; we = ~w; addr = ~a; wdata = ~d; funct3 = 3'b111;
      nb  = 0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy) nb++;
         if (ready) begin
            got = 1'b1;
            break;
         end
         if (toggle) req = ~req;
         @(negedge clk);
      end
      req = 1'b0;
      check("ready_seen", 32'(got), 32'd1);
      check("busy_cycles", 32'(nb), 32'(W + 2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected end of run");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b0;

      xact(1, 10'h010, 32'h12345678, 3'b010, 32'h0, 0, 0);
      xact(0, 10'h010, 32'h0,        3'b010, 32'h12345678, 0, 0);
      xact(1, 10'h011, 32'h000000AB, 3'b000, 32'h0, 0, 0);
      xact(0, 10'h010, 32'h0,        3'b010, 32'h1234AB78, 0, 0);
      xact(0, 10'h011, 32'h0,        3'b000, 32'hFFFFFFAB, 0, 0);
      xact(0, 10'h011, 32'h0,        3'b100, 32'h000000AB, 0, 0);
      xact(1, 10'h012, 32'h00008001, 3'b001, 32'h0, 0, 0);
      xact(0, 10'h012, 32'h0,        3'b001, 32'hFFFF8001, 0, 0);
      xact(0, 10'h012, 32'h0,        3'b101, 32'h00008001, 0, 0);
      xact(0, 10'h010, 32'h0,        3'b010, 32'h8001AB78, 0, 0);
      xact(0, 10'h010, 32'h0,        3'b000, 32'h00000078, 0, 1);
      xact(0, 10'h010, 32'h0,        3'b011, 32'h00000000, 1, 1);
      xact(1, 10'h010, 32'hFFFFFFFF, 3'b011, 32'h0, 1, 0);
      xact(0, 10'h010, 32'h0,        3'b010, 32'h8001AB78, 0, 0);
`ifdef MISALIGN_TRAP_EN
      xact(1, 10'h013, 32'hDEADBEEF, 3'b010, 32'h0, 1, 0);
      xact(0, 10'h010, 32'h0,        3'b010, 32'h8001AB78, 0, 0);
      xact(0, 10'h011, 32'h0,        3'b001, 32'h00000000, 1, 0);
      xact(0, 10'h013, 32'h0,        3'b000, 32'hFFFFFF80, 0, 0);
      xact(0, 10'h012, 32'h0,        3'b101, 32'h00008001, 0, 0);
`else
      xact(1, 10'h013, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
      xact(0, 10'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
      xact(0, 10'h011, 32'h0,        3'b001, 32'hFFFFBEEF, 0, 0);
      xact(0, 10'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 0, 0);
      xact(0, 10'h012, 32'h0,        3'b101, 32'h0000DEAD, 0, 0);
`endif
      xact(1, 10'h020, 32'h11112222, 3'b010, 32'h0, 0, 0);

      // Store aborted by reset during WAIT must never reach the RAM
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'hCAFEF00D; funct3 = 3'b010;
      @(negedge clk);
      req = 1'b0;
      check("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy_async", 32'(busy), 32'd0);
      check("abort_rdata", rdata, 32'd0);
      @(negedge clk);
      check("abort_busy_next", 32'(busy), 32'd0);
      reset = 1'b0;
      last_rd = 32'd0;
      repeat (8) @(negedge clk);
      check("abort_no_ready", 32'(ready), 32'd0);
      xact(0, 10'h020, 32'h0, 3'b010, 32'h11112222, 0, 0);

      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Data-memory slave on the CPU data bus; the responding end of the multi-cycle core's load/store traffic.
- Accepts one request at a time and applies RISC-V byte, half and word store strobes as read-modify-write on a word RAM.
- Returns sign- or zero-extended load data with a registered ready pulse, after a programmable number of wait states.
- Sits between the core's bus port (we, addr, wdata, funct3) and the data RAM.

Parameters:
- DEPTH, 256, number of 32-bit words in RAM (power of 2).
- WAIT_CYCLES, 1, extra wait states inserted before the access (0..15).
- ADDR_W, $clog2(DEPTH)+2, byte-address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data, right-justified.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  extended load data; valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.
- err  output  1  access error, qualified by ready.

Behaviour:
- Clock and reset: reset is reset (asynchronous, active-high); clock is clk.
- Reset values: state=IDLE, rdata=0, ready=0, busy=0, err=0, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - If req=1, latch we, addr, wdata and funct3.
  - Go to WAIT with counter=WAIT_CYCLES-1, or straight to XFER if WAIT_CYCLES=0.
- WAIT: decrement the counter; go to XFER when it reaches 0.
- XFER:
  - Store: byte-lane write commits at the XFER clock edge.
  - Load: word read; extended result registered into rdata at the same edge.
  - Next state is DONE.
- DONE: ready=1 for exactly one cycle; next state is IDLE.
- Latency: req high in IDLE at cycle t gives ready high at cycle t+WAIT_CYCLES+2.
- Back-to-back requests: next request accepted in IDLE one cycle after ready.
- req asserted in WAIT, XFER or DONE is ignored; the master holds or re-asserts it.
- Latched fields are held for the whole transaction; input changes after acceptance have no effect.
- Word index is addr[ADDR_W-1:2]; the address space wraps naturally.
- Store lanes:
  - Byte: lane addr[1:0] receives wdata[7:0].
  - Half: lane pair addr[1] receives wdata[15:0].
  - Word: all four lanes.
  - All other bytes are unchanged.
- Load extraction:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - funct3[2]=0 sign-extends to 32 bits; funct3[2]=1 zero-extends.
- Unsupported funct3 (011, 110, 111):
  - Store is a no-op; load returns rdata=0.
  - err=1 in DONE.
- rdata holds its value after DONE until the next load completes; stores leave rdata unchanged.
- Reset mid-transaction: return to IDLE immediately, no ready pulse. A store not yet past its XFER edge never commits.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, performs no RAM write and returns rdata=0.
  - err=1 with ready; latency unchanged.
- Undefined:
  - Misaligned addresses are aligned down (ignore addr[0] for half, addr[1:0] for word).
  - err is asserted only for unsupported funct3.

Test Plan:
- WAIT_CYCLES=2; SW 0x12345678 at 0x10, then LW 0x10 -> rdata=0x12345678, err=0, ready exactly 4 cycles after req, busy high for those 4 cycles.
- SB wdata=0x000000AB at 0x11, then LW 0x10 -> 0x1234AB78; LB 0x11 -> 0xFFFFFFAB; LBU 0x11 -> 0x000000AB.
- SH 0x00008001 at 0x12, then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001; LW 0x10 -> 0x8001AB78.
- req toggled during WAIT/XFER and funct3=011 load -> extra requests ignored, one ready per transaction, 011 returns rdata=0 with err=1.
- With MISALIGN_TRAP_EN: SW 0xDEADBEEF at 0x13 -> err=1, LW 0x10 still 0x8001AB78; without the macro the same SW writes word 0x10 -> 0xDEADBEEF.
- SW 0xCAFEF00D at 0x20 with reset pulsed during WAIT -> no ready, busy=0 next cycle, later LW 0x20 returns the prior contents.
